// File: rtl/multiword_add_seq.sv
// Wide unsigned adder built from one 8-bit ripple adder that is stepped over
// NBYTES byte lanes, LSB first, with the carry held in a register between cycles.
// Operands arrive on a valid/ready handshake; the result leaves on another.

// 8-bit ripple-carry adder used as the single arithmetic slice.
module ripple_adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] s,
   output logic       cout
);

   // Bit-serial carry chain across the byte.
   always_comb begin : chain
      logic c;
      c = cin;
      s = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

module multiword_add_seq #(
   parameter int unsigned NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   a,
   input  logic [8*NBYTES-1:0]   b,
   input  logic                  cin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   sum,
   output logic                  cout,
   output logic                  busy
);

   localparam int unsigned W  = 8 * NBYTES;
   localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_sh_q, a_sh_d;
   logic [W-1:0]    b_sh_q, b_sh_d;
   logic [W-1:0]    res_q, res_d;
   logic [W-1:0]    sum_q, sum_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic            cout_q, cout_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic            busy_q, busy_d;

   logic [7:0]      add_s;
   logic            add_co;

   ripple_adder u_adder (
      .a    (a_sh_q[7:0]),
      .b    (b_sh_q[7:0]),
      .cin  (carry_q),
      .s    (add_s),
      .cout (add_co)
   );

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               idx_d   = '0;
               res_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Byte write via a constant-select loop so every slice stays in range,
            // including the NBYTES==1 case where idx has a spare bit.
            for (int unsigned k = 0; k < NBYTES; k++) begin
               if (idx_q == IW'(k)) begin
                  res_d[k*8 +: 8] = add_s;
               end
            end
            carry_d = add_co;
            a_sh_d  = a_sh_q >> 8;
            b_sh_d  = b_sh_q >> 8;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST) begin
               sum_d   = res_d;
               cout_d  = add_co;
               idx_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         res_q       <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         res_q       <= res_d;
         sum_q       <= sum_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq: NBYTES=4 instance for the main
// scenarios plus an NBYTES=1 instance for the single-lane corner.

module tb_multiword_add_seq;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;

   logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
   logic [31:0] a, b, sum;

   logic        in_valid_1, in_ready_1, cin_1, out_valid_1, out_ready_1, cout_1, busy_1;
   logic [7:0]  a_1, b_1, sum_1;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int          cyc      = 0;

   always @(posedge clk) cyc++;

   multiword_add_seq #(.NBYTES(4)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   multiword_add_seq #(.NBYTES(1)) u_dut1 (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid_1),
      .in_ready  (in_ready_1),
      .a         (a_1),
      .b         (b_1),
      .cin       (cin_1),
      .out_valid (out_valid_1),
      .out_ready (out_ready_1),
      .sum       (sum_1),
      .cout      (cout_1),
      .busy      (busy_1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for out_valid on the 4-byte DUT; returns cycles waited.
   task automatic wait_done(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic cv, input logic [31:0] es, input logic ec);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_rdy"}, 64'(in_ready), 64'd1);
      a = av; b = bv; cin = cv; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, "_busy"}, 64'(busy), 64'd1);
      wait_done(n);
      check({tag, "_lat"}, 64'(n), 64'd4);
      check({tag, "_sum"}, 64'(sum), 64'(es));
      check({tag, "_cout"}, 64'(cout), 64'(ec));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_ovlo"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      int          n;
      logic [31:0] op_a [3];
      logic [31:0] op_b [3];
      logic        op_c [3];
      int          acc_cyc [3];
      int          k_acc, k_done;
      logic        acc;
      logic [32:0] model;

      reset_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      in_valid_1 = 1'b0; out_ready_1 = 1'b0; a_1 = '0; b_1 = '0; cin_1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdy",   64'(in_ready),   64'd1);
      check("rst_ov",    64'(out_valid),  64'd0);
      check("rst_busy",  64'(busy),       64'd0);
      check("rst_sum",   64'(sum),        64'd0);
      check("rst_cout",  64'(cout),       64'd0);
      check("rst1_rdy",  64'(in_ready_1), 64'd1);
      check("rst1_sum",  64'(sum_1),      64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      run_op("ovf", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
      run_op("cin", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0);
      run_op("mix", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);

      // Back-pressure in DONE with a new operand set waiting.
      a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_done(n);
      check("stall_lat", 64'(n), 64'd4);
      a = 32'h7000_0000; b = 32'h9000_0001; cin = 1'b1; in_valid = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         check("stall_ov",  64'(out_valid), 64'd1);
         check("stall_rdy", 64'(in_ready),  64'd0);
         check("stall_sum", 64'(sum),       64'h100);
         check("stall_co",  64'(cout),      64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("hs_ov",  64'(out_valid), 64'd0);
      check("hs_rdy", 64'(in_ready),  64'd1);
      check("hs_sum", 64'(sum),       64'h100);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("acc2_rdy",  64'(in_ready), 64'd0);
      check("acc2_busy", 64'(busy),     64'd1);
      wait_done(n);
      check("acc2_lat",  64'(n),    64'd4);
      check("acc2_sum",  64'(sum),  64'h0000_0002);
      check("acc2_cout", 64'(cout), 64'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset during the second RUN cycle aborts the operation.
      a = 32'h0F0F_0F0F; b = 32'h0101_0101; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      check("mrst_rdy",  64'(in_ready),  64'd1);
      check("mrst_ov",   64'(out_valid), 64'd0);
      check("mrst_sum",  64'(sum),       64'd0);
      check("mrst_cout", 64'(cout),      64'd0);
      check("mrst_busy", 64'(busy),      64'd0);
      reset_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("mrst_nores", 64'(out_valid), 64'd0);
      run_op("post", 32'd5, 32'd7, 1'b0, 32'd12, 1'b0);

      // Streaming with in_valid and out_ready held high.
      for (int i = 0; i < 3; i++) begin
         op_a[i]    = $urandom;
         op_b[i]    = $urandom;
         op_c[i]    = 1'($urandom_range(0, 1));
         acc_cyc[i] = 0;
      end
      a = op_a[0]; b = op_b[0]; cin = op_c[0];
      in_valid = 1'b1; out_ready = 1'b1;
      k_acc = 0; k_done = 0;
      for (int t = 0; t < 60 && k_done < 3; t++) begin
         @(negedge clk);
         acc = 1'b0;
         if (in_valid && in_ready && k_acc < 3) begin
            acc_cyc[k_acc] = cyc;
            acc = 1'b1;
         end
         if (out_valid) begin
            model = {1'b0, op_a[k_done]} + {1'b0, op_b[k_done]} + 33'(op_c[k_done]);
            check("thr_sum",  64'(sum),  64'(model[31:0]));
            check("thr_cout", 64'(cout), 64'(model[32]));
            k_done++;
         end
         @(posedge clk); #1;
         if (acc) begin
            k_acc++;
            if (k_acc < 3) begin
               a = op_a[k_acc]; b = op_b[k_acc]; cin = op_c[k_acc];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("thr_ndone", 64'(k_done), 64'd3);
      check("thr_gap1",  64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
      check("thr_gap2",  64'(acc_cyc[2] - acc_cyc[1]), 64'd6);

      // Single-lane instance.
      @(posedge clk); #1;
      a_1 = 8'hFF; b_1 = 8'h01; cin_1 = 1'b1; in_valid_1 = 1'b1;
      @(posedge clk); #1;
      in_valid_1 = 1'b0;
      n = 0;
      while (!out_valid_1 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check("n1_lat",  64'(n),      64'd1);
      check("n1_sum",  64'(sum_1),  64'h01);
      check("n1_cout", 64'(cout_1), 64'd1);
      out_ready_1 = 1'b1;
      @(posedge clk); #1;
      out_ready_1 = 1'b0;
      check("n1_ovlo", 64'(out_valid_1), 64'd0);
      check("n1_rdy",  64'(in_ready_1),  64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
